// File: rtl/i_ddr_word_deser.sv
// DDR input word deserializer.
// Packs the 2-bit pairs from an I_DDR capture cell into WORD_WIDTH-bit words, LSB first.
// A bit-slip request drops one pair so the word boundary can be aligned.
// Finished words go into a first-word-fall-through FIFO with a valid/ready handshake.
// A sticky OVERFLOW flag records any word dropped because the FIFO was full.
module i_ddr_word_deser #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          R,
    input  logic [1:0]                    DDR_D,
    input  logic                          DDR_EN,
    input  logic                          BITSLIP,
    input  logic                          CLR_OVF,
    output logic [WORD_WIDTH-1:0]         WORD_OUT,
    output logic                          WORD_VALID,
    input  logic                          WORD_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          OVERFLOW
);

    localparam int unsigned NumPairs = WORD_WIDTH / 2;
    localparam int unsigned PairW    = $clog2(NumPairs);
    localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LevelW   = AddrW + 1;

    localparam logic [PairW-1:0]  LastPair  = PairW'(NumPairs - 1);
    localparam logic [LevelW-1:0] FullLevel = LevelW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Assembler state
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [PairW-1:0]      pcnt_q, pcnt_d;
    logic                  slip_q, slip_d;
    logic                  push_req;
    logic [WORD_WIDTH-1:0] push_word;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]     count_q, count_d;
    logic [WORD_WIDTH-1:0] last_q, last_d;
    logic                  ovf_q, ovf_d;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;
    logic push_drop;

    // Next-state for the pair assembler and bit-slip flag.
    always_comb begin
        shift_d   = shift_q;
        pcnt_d    = pcnt_q;
        slip_d    = slip_q;
        push_req  = 1'b0;
        // Shift register with the incoming pair merged in; this is the finished
        // word when the pair lands in the top slot.
        push_word = shift_q;
        push_word[{pcnt_q, 1'b0} +: 2] = DDR_D;

        if (DDR_EN) begin
            if (slip_q || BITSLIP) begin
                // Dropped pair: position unchanged, one slip consumed.
                slip_d = 1'b0;
            end else begin
                shift_d = push_word;
                if (pcnt_q == LastPair) begin
                    pcnt_d   = '0;
                    push_req = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
        end else if (BITSLIP) begin
            slip_d = 1'b1;
        end
    end

    // Assembler registers.
    always_ff @(posedge CLK) begin
        if (R) begin
            shift_q <= '0;
            pcnt_q  <= '0;
            slip_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            pcnt_q  <= pcnt_d;
            slip_q  <= slip_d;
        end
    end

    // FIFO control: handshake decode, pointer/level update, sticky overflow.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FullLevel);
        pop        = !fifo_empty && WORD_READY;
        // A simultaneous pop frees a slot, so a full FIFO still accepts the word.
        push_ok    = push_req && (!fifo_full || pop);
        push_drop  = push_req && fifo_full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        ovf_d    = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
        end
        if (push_ok && !pop) begin
            count_d = count_q + LevelW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - LevelW'(1);
        end

        // Setting has priority over clearing.
        if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
        if (push_drop) begin
            ovf_d = 1'b1;
        end
    end

    // FIFO registers and storage.
    always_ff @(posedge CLK) begin
        if (R) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
            end
        end
    end

    // Outputs: head of FIFO falls through; hold the last popped word when empty.
    always_comb begin
        WORD_VALID = (count_q != '0);
        WORD_OUT   = WORD_VALID ? mem_q[rd_ptr_q] : last_q;
        FIFO_LEVEL = count_q;
        OVERFLOW   = ovf_q;
    end

endmodule

// File: tb/tb_i_ddr_word_deser.sv
// Bench for i_ddr_word_deser: directed scenarios with literal expectations, then a long
// random run, all shadowed by a bit-queue/word-queue reference model checked every cycle.
module tb_i_ddr_word_deser;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          r, en, bs, clr, rdy;
    logic [1:0]    d;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic [LW-1:0] level;
    logic          ovf;

    always #5 clk = ~clk;

    i_ddr_word_deser #(
        .WORD_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .CLK        (clk),
        .R          (r),
        .DDR_D      (d),
        .DDR_EN     (en),
        .BITSLIP    (bs),
        .CLR_OVF    (clr),
        .WORD_OUT   (word_out),
        .WORD_VALID (word_valid),
        .WORD_READY (rdy),
        .FIFO_LEVEL (level),
        .OVERFLOW   (ovf)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model: received bits in arrival order, words in a plain queue.
    bit           m_bits[$];
    logic [W-1:0] m_fifo[$];
    logic [W-1:0] m_last;
    bit           m_slip;
    bit           m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit           pop;
        bit           push;
        logic [W-1:0] w;
        if (r) begin
            m_bits.delete();
            m_fifo.delete();
            m_last = '0;
            m_slip = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        pop  = (m_fifo.size() > 0) && rdy;
        push = 1'b0;
        w    = '0;
        if (en) begin
            if (m_slip || bs) begin
                m_slip = 1'b0;
            end else begin
                m_bits.push_back(d[0]);
                m_bits.push_back(d[1]);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = m_bits[i];
                    m_bits.delete();
                    push = 1'b1;
                end
            end
        end else if (bs) begin
            m_slip = 1'b1;
        end
        if (clr) m_ovf = 1'b0;
        if (pop) m_last = m_fifo.pop_front();
        if (push) begin
            if (m_fifo.size() < D) m_fifo.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid", {31'b0, word_valid}, {31'b0, m_fifo.size() != 0});
            chk("word_out", 32'(word_out), 32'(m_fifo.size() != 0 ? m_fifo[0] : m_last));
            chk("level", 32'(level), 32'(m_fifo.size()));
            chk("overflow", {31'b0, ovf}, {31'b0, m_ovf});
        end
    end

    task automatic step(input logic r_, input logic [1:0] d_, input logic en_,
                        input logic bs_, input logic clr_, input logic rdy_);
        r   = r_;
        d   = d_;
        en  = en_;
        bs  = bs_;
        clr = clr_;
        rdy = rdy_;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic pair(input logic [1:0] p, input logic rdy_);
        step(1'b0, p, 1'b1, 1'b0, 1'b0, rdy_);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic rdy_);
        for (int k = 0; k < W / 2; k++) pair(w[2*k +: 2], rdy_);
    endtask

    task automatic idle(input logic rdy_);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, rdy_);
    endtask

    initial begin
        logic [W-1:0] exp_w[5];

        // Reset
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_en = 1'b1;
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst_word", 32'(word_out), 32'h0);
        chk("rst_valid", {31'b0, word_valid}, 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'h0);

        // Basic assembly: 01,10,11,00 -> 0x39, valid for one cycle
        pair(2'b01, 1'b1);
        pair(2'b10, 1'b1);
        pair(2'b11, 1'b1);
        chk("pre_valid", {31'b0, word_valid}, 32'h0);
        pair(2'b00, 1'b1);
        chk("asm_valid", {31'b0, word_valid}, 32'h1);
        chk("asm_word", 32'(word_out), 32'h39);
        idle(1'b1);
        chk("pop_valid", {31'b0, word_valid}, 32'h0);
        chk("hold_word", 32'(word_out), 32'h39);

        // Bit-slip drops the next pair
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        pair(2'b11, 1'b1);
        send_word(8'h39, 1'b1);
        chk("slip_word", 32'(word_out), 32'h39);
        chk("slip_valid", {31'b0, word_valid}, 32'h1);
        idle(1'b1);
        // Three more slips, one collapsed double request and one same-cycle slip
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        pair(2'b10, 1'b1);
        step(1'b0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        pair(2'b11, 1'b1);
        send_word(8'hA6, 1'b1);
        chk("reslip_word", 32'(word_out), 32'hA6);
        idle(1'b1);

        // Overflow: five words with READY low
        exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_word(exp_w[i], 1'b0);
        chk("ovf_level", 32'(level), 32'h4);
        chk("ovf_set", {31'b0, ovf}, 32'h1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr", {31'b0, ovf}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_word", 32'(word_out), 32'(exp_w[i]));
            idle(1'b1);
        end
        chk("drain_level", 32'(level), 32'h0);

        // Full FIFO, push with pop at the same edge
        for (int i = 0; i < 4; i++) send_word(8'hA1 + W'(i), 1'b0);
        pair(2'b01, 1'b0);
        pair(2'b01, 1'b0);
        pair(2'b10, 1'b0);
        pair(2'b10, 1'b1);
        chk("fullpp_level", 32'(level), 32'h4);
        chk("fullpp_ovf", {31'b0, ovf}, 32'h0);
        chk("fullpp_head", 32'(word_out), 32'hA2);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("fullpp_tail", 32'(word_out), 32'hA5);
        idle(1'b1);

        // Reset mid-word discards partial bits
        pair(2'b11, 1'b0);
        pair(2'b11, 1'b0);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_word", 32'(word_out), 32'h0);
        chk("midrst_valid", {31'b0, word_valid}, 32'h0);
        pair(2'b00, 1'b0);
        pair(2'b00, 1'b0);
        pair(2'b00, 1'b0);
        pair(2'b11, 1'b0);
        chk("midrst_new", 32'(word_out), 32'hC0);
        idle(1'b1);

        // Gaps between pairs
        for (int k = 0; k < W / 2; k++) begin
            logic [W-1:0] gw;
            gw = 8'h5A;
            pair(gw[2*k +: 2], 1'b0);
            idle(1'b0);
            idle(1'b0);
        end
        chk("gap_word", 32'(word_out), 32'h5A);
        chk("gap_level", 32'(level), 32'h1);
        idle(1'b1);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            step(($urandom_range(0, 199) == 0), 2'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 2 : 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
